// File: rtl/fetch_stage_pkg.sv
// Shared constants and bus layout for the instruction fetch stage and its
// neighbours (next-PC generator, decode).
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC   = 32'hbfbffffc;
  localparam logic [31:0] EXC_VECTOR = 32'hbfc00380;
  localparam int          FE_DE_W    = 65;

  localparam int FE_ADEL_BIT = 64;
  localparam int FE_PC_HI    = 63;
  localparam int FE_PC_LO    = 32;
  localparam int FE_INST_HI  = 31;
  localparam int FE_INST_LO  = 0;

  typedef struct packed {
    logic        adel;
    logic [31:0] pc;
    logic [31:0] inst;
  } fe_de_bus_t;

  function automatic logic [FE_DE_W-1:0] pack_fe_de(input logic        adel,
                                                    input logic [31:0] pc,
                                                    input logic [31:0] inst);
    fe_de_bus_t b;
    b.adel = adel;
    b.pc   = pc;
    b.inst = inst;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signals between the fetch stage, the next-PC generator, the instruction
// SRAM and decode. The fetch stage takes the master view.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic [31:0]        nextpc;
  logic               de_pc_err;
  logic               exc_flush;
  logic               de_allowin;
  logic [31:0]        inst_sram_rdata;
  logic               inst_sram_en;
  logic [31:0]        fe_pc;
  logic               fe_to_de_valid;
  logic [FE_DE_W-1:0] fe_to_de_bus;

  modport master (
    input  nextpc, de_pc_err, exc_flush, de_allowin, inst_sram_rdata,
    output inst_sram_en, fe_pc, fe_to_de_valid, fe_to_de_bus
  );

  modport slave (
    output nextpc, de_pc_err, exc_flush, de_allowin, inst_sram_rdata,
    input  inst_sram_en, fe_pc, fe_to_de_valid, fe_to_de_bus
  );
endinterface

// File: rtl/fetch_stage_inst_buf.sv
// Stall-hold register for synchronous SRAM read data: captures the word on the
// first stalled cycle and replays it until the stage advances.
module fe_inst_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         capture,
  input  logic         clear,
  input  logic         kill,
  input  logic [W-1:0] rdata,
  output logic [W-1:0] data_out,
  output logic         buf_valid
);

  logic [W-1:0] inst_buf_reg;
  logic         buf_valid_reg;

  // Only the first stalled cycle captures; the SRAM is not re-enabled while
  // holding, so later rdata is not trustworthy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_buf_reg  <= '0;
      buf_valid_reg <= 1'b0;
    end else if (clear) begin
      buf_valid_reg <= 1'b0;
    end else if (capture && !buf_valid_reg) begin
      inst_buf_reg  <= rdata;
      buf_valid_reg <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_mux
      assign data_out[gi] = ~kill & (buf_valid_reg ? inst_buf_reg[gi] : rdata[gi]);
    end
  endgenerate

  assign buf_valid = buf_valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// IF pipeline stage: registers the next-PC choice, drives the instruction SRAM
// enable and hands {adel, pc, inst} to decode with a valid/allowin handshake.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  fetch_stage_if.master  fe_if
);

  logic [31:0] fe_pc_reg;
  logic        fe_valid_reg;
  logic        adel_reg;

  logic        fe_ready_go;
  logic        fe_allowin;
  logic        advance;
  logic        hold;
  logic [31:0] inst;
  logic        buf_valid;

  assign fe_ready_go = 1'b1;
  assign fe_allowin  = ~fe_valid_reg | (fe_ready_go & fe_if.de_allowin);

  // A flush redirects even while decode is stalled.
  assign advance = resetn & (fe_allowin | fe_if.exc_flush);
  assign hold    = fe_valid_reg & ~fe_if.de_allowin & ~fe_if.exc_flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fe_pc_reg    <= RESET_PC;
      fe_valid_reg <= 1'b0;
      adel_reg     <= 1'b0;
    end else if (advance) begin
      fe_pc_reg    <= fe_if.nextpc;
      fe_valid_reg <= 1'b1;
      adel_reg     <= fe_if.de_pc_err;
    end
  end

  // A misaligned fetch presents a NOP; decode raises AdEL from the flag.
  fe_inst_buf #(
    .W (32)
  ) u_inst_buf (
    .clk       (clk),
    .resetn    (resetn),
    .capture   (hold),
    .clear     (advance),
    .kill      (adel_reg),
    .rdata     (fe_if.inst_sram_rdata),
    .data_out  (inst),
    .buf_valid (buf_valid)
  );

  assign fe_if.inst_sram_en   = advance;
  assign fe_if.fe_pc          = fe_pc_reg;
  assign fe_if.fe_to_de_valid = fe_valid_reg & fe_ready_go & ~fe_if.exc_flush;
  assign fe_if.fe_to_de_bus   = pack_fe_de(adel_reg, fe_pc_reg, inst);

  logic unused_ok;
  assign unused_ok = buf_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle model of the stage contract plus
// literal expectations at the key points of each scenario.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if fe_if ();

  fetch_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .fe_if  (fe_if)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Model: what IF must present, from the stage contract. A word is "pinned"
  // once decode has refused it: the value seen on its first cycle is what
  // decode must keep seeing.
  logic        m_init   = 1'b0;
  logic [31:0] m_pc     = '0;
  logic        m_valid  = 1'b0;
  logic        m_adel   = 1'b0;
  logic        m_pinned = 1'b0;
  logic [31:0] m_word   = '0;

  always @(posedge clk) begin
    if (!resetn) begin
      m_init   <= 1'b1;
      m_pc     <= RESET_PC;
      m_valid  <= 1'b0;
      m_adel   <= 1'b0;
      m_pinned <= 1'b0;
    end else if (m_init) begin
      if (!m_valid || fe_if.de_allowin || fe_if.exc_flush) begin
        m_pc     <= fe_if.nextpc;
        m_valid  <= 1'b1;
        m_adel   <= fe_if.de_pc_err;
        m_pinned <= 1'b0;
      end else if (!m_pinned) begin
        m_pinned <= 1'b1;
        m_word   <= fe_if.inst_sram_rdata;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      logic [31:0] exp_inst;
      exp_inst = m_adel ? 32'h0 : (m_pinned ? m_word : fe_if.inst_sram_rdata);
      chk("model_pc", 65'(fe_if.fe_pc), 65'(m_pc));
      chk("model_valid", 65'(fe_if.fe_to_de_valid), 65'(m_valid & ~fe_if.exc_flush));
      chk("model_en", 65'(fe_if.inst_sram_en),
          65'(resetn & (~m_valid | fe_if.de_allowin | fe_if.exc_flush)));
      if (m_valid)
        chk("model_bus", fe_if.fe_to_de_bus, {m_adel, m_pc, exp_inst});
    end
  end

  task automatic drive(input logic rn, input logic [31:0] np, input logic err,
                       input logic fl, input logic al, input logic [31:0] rd);
    @(posedge clk);
    #1;
    cyc++;
    resetn                = rn;
    fe_if.nextpc          = np;
    fe_if.de_pc_err       = err;
    fe_if.exc_flush       = fl;
    fe_if.de_allowin      = al;
    fe_if.inst_sram_rdata = rd;
    @(negedge clk);
  endtask

  initial begin
    fe_if.nextpc          = 32'h0;
    fe_if.de_pc_err       = 1'b0;
    fe_if.exc_flush       = 1'b0;
    fe_if.de_allowin      = 1'b0;
    fe_if.inst_sram_rdata = 32'h0;

    // Reset held for three edges.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_valid", 65'(fe_if.fe_to_de_valid), 65'd0);
    chk("rst_en", 65'(fe_if.inst_sram_en), 65'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Release: first fetch address issued.
    drive(1'b1, 32'hbfc00000, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("rel_pc", 65'(fe_if.fe_pc), 65'h0_bfbffffc);
    chk("rel_valid", 65'(fe_if.fe_to_de_valid), 65'd0);
    chk("rel_en", 65'(fe_if.inst_sram_en), 65'd1);

    // Streaming.
    drive(1'b1, 32'hbfc00004, 1'b0, 1'b0, 1'b1, 32'h11110000);
    chk("s0_bus", fe_if.fe_to_de_bus, {1'b0, 32'hbfc00000, 32'h11110000});
    chk("s0_valid", 65'(fe_if.fe_to_de_valid), 65'd1);
    drive(1'b1, 32'hbfc00008, 1'b0, 1'b0, 1'b1, 32'h22221111);
    chk("s1_bus", fe_if.fe_to_de_bus, {1'b0, 32'hbfc00004, 32'h22221111});

    // Stall at bfc00008; rdata turns to garbage after the first cycle.
    drive(1'b1, 32'hbfc0000c, 1'b0, 1'b0, 1'b0, 32'h33332222);
    chk("st0_en", 65'(fe_if.inst_sram_en), 65'd0);
    drive(1'b1, 32'hbfc0000c, 1'b0, 1'b0, 1'b0, 32'hdeadbeef);
    chk("st1_bus", fe_if.fe_to_de_bus, {1'b0, 32'hbfc00008, 32'h33332222});
    drive(1'b1, 32'hbfc0000c, 1'b0, 1'b0, 1'b0, 32'hbad0bad0);
    chk("st2_bus", fe_if.fe_to_de_bus, {1'b0, 32'hbfc00008, 32'h33332222});
    chk("st2_en", 65'(fe_if.inst_sram_en), 65'd0);

    // Flush during the stall.
    drive(1'b1, EXC_VECTOR, 1'b0, 1'b1, 1'b0, 32'hcafecafe);
    chk("fl_valid", 65'(fe_if.fe_to_de_valid), 65'd0);
    chk("fl_en", 65'(fe_if.inst_sram_en), 65'd1);
    drive(1'b1, 32'hbfc00384, 1'b0, 1'b0, 1'b1, 32'h44444444);
    chk("fl_bus", fe_if.fe_to_de_bus, {1'b0, 32'hbfc00380, 32'h44444444});

    // Misaligned fetch.
    drive(1'b1, 32'hbfc00012, 1'b1, 1'b0, 1'b1, 32'h45454545);
    drive(1'b1, 32'hbfc00014, 1'b0, 1'b0, 1'b1, 32'h55555555);
    chk("adel_bus", fe_if.fe_to_de_bus, {1'b1, 32'hbfc00012, 32'h00000000});
    chk("adel_valid", 65'(fe_if.fe_to_de_valid), 65'd1);

    // Stall again, then reset while the buffer is holding.
    drive(1'b1, 32'hbfc00018, 1'b0, 1'b0, 1'b0, 32'h66666666);
    drive(1'b1, 32'hbfc00018, 1'b0, 1'b0, 1'b0, 32'h77777777);
    chk("st3_bus", fe_if.fe_to_de_bus, {1'b0, 32'hbfc00014, 32'h66666666});
    drive(1'b0, 32'hbfc00018, 1'b0, 1'b0, 1'b0, 32'h12121212);
    chk("rstm_en", 65'(fe_if.inst_sram_en), 65'd0);
    drive(1'b1, 32'hbfc00000, 1'b0, 1'b0, 1'b0, 32'h88888888);
    chk("rstm_pc", 65'(fe_if.fe_pc), 65'h0_bfbffffc);
    chk("rstm_valid", 65'(fe_if.fe_to_de_valid), 65'd0);
    drive(1'b1, 32'hbfc00004, 1'b0, 1'b0, 1'b0, 32'h99999999);
    chk("rstm_fresh", fe_if.fe_to_de_bus, {1'b0, 32'hbfc00000, 32'h99999999});
    drive(1'b1, 32'hbfc00004, 1'b0, 1'b0, 1'b1, 32'haaaaaaaa);
    chk("rstm_hold", fe_if.fe_to_de_bus, {1'b0, 32'hbfc00000, 32'h99999999});

    // Wrap addresses pass through unmodified.
    drive(1'b1, 32'hfffffffc, 1'b0, 1'b0, 1'b1, 32'hbbbbbbbb);
    chk("s2_bus", fe_if.fe_to_de_bus, {1'b0, 32'hbfc00004, 32'hbbbbbbbb});
    drive(1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'hcccccccc);
    chk("wrap_pc", 65'(fe_if.fe_pc), 65'h0_fffffffc);
    drive(1'b1, 32'h00000004, 1'b0, 1'b0, 1'b1, 32'hdddddddd);
    chk("zero_pc", 65'(fe_if.fe_pc), 65'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
